// File: rtl/div_sign_restore.sv
// Sign-restore stage for the signed divider: turns unsigned quotient/remainder
// magnitudes back into two's-complement results through a 2-stage elastic pipeline.
module div_sign_restore #(
    parameter int WL = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WL-1:0] q_mag,
    input  logic [WL-1:0] r_mag,
    input  logic          sign_a,
    input  logic          sign_b,
    input  logic          div_zero,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WL-1:0] quot,
    output logic [WL-1:0] rem,
    output logic          ovf,
    output logic          dz,
    output logic [CW-1:0] ovf_cnt
);

    localparam logic [WL-1:0] MIN_NEG = {1'b1, {(WL-1){1'b0}}};
    localparam logic [WL-1:0] MAX_POS = {1'b0, {(WL-1){1'b1}}};
    localparam logic [CW-1:0] CNT_MAX = '1;

    // Handshake: a beat moves on a port when valid && ready at the rising edge;
    // a stage loads when it is empty or its contents leave in the same cycle,
    // and ready never depends on the incoming valid.
    logic          s1_valid;
    logic [WL-1:0] s1_q;
    logic [WL-1:0] s1_r;
    logic          s1_sa;
    logic          s1_sb;
    logic          s1_dz;

    logic s2_adv;
    logic s1_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    logic          qs;
    logic [WL-1:0] neg_q;
    logic [WL-1:0] neg_r;
    logic          pos_ovf;
    logic          neg_ovf;
    logic [WL-1:0] nxt_quot;
    logic [WL-1:0] nxt_rem;
    logic          nxt_ovf;
    logic          nxt_dz;

    always_comb begin
        qs      = s1_sa ^ s1_sb;
        neg_q   = '0 - s1_q;
        neg_r   = '0 - s1_r;
        pos_ovf = !qs && s1_q[WL-1];
        // q_mag == 2^(WL-1) with a negative quotient is exactly representable
        neg_ovf = qs && (s1_q > MIN_NEG);
    end

    always_comb begin
        nxt_quot = qs ? neg_q : s1_q;
        nxt_rem  = s1_sa ? neg_r : s1_r;
        nxt_ovf  = 1'b0;
        nxt_dz   = 1'b0;
        if (s1_dz) begin
            nxt_quot = '1;
            nxt_dz   = 1'b1;
        end else if (pos_ovf) begin
            nxt_quot = MAX_POS;
            nxt_ovf  = 1'b1;
        end else if (neg_ovf) begin
            nxt_quot = MIN_NEG;
            nxt_ovf  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s1_r     <= '0;
            s1_sa    <= 1'b0;
            s1_sb    <= 1'b0;
            s1_dz    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q  <= q_mag;
                s1_r  <= r_mag;
                s1_sa <= sign_a;
                s1_sb <= sign_b;
                s1_dz <= div_zero;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            quot      <= '0;
            rem       <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                quot <= nxt_quot;
                rem  <= nxt_rem;
                ovf  <= nxt_ovf;
                dz   <= nxt_dz;
            end
        end
    end

    // Counts delivered overflow beats, not accepted ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (out_valid && out_ready && ovf && (ovf_cnt != CNT_MAX)) begin
            ovf_cnt <= ovf_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_div_sign_restore.sv
// Directed bench for div_sign_restore (WL=8, CW=2): vector table, latency,
// backpressure, counter saturation and mid-stream reset.
module tb_div_sign_restore;

  localparam int WL = 8;
  localparam int CW = 2;
  localparam int EW = 2 * WL + 2;

  typedef struct {
    logic [WL-1:0] q;
    logic [WL-1:0] r;
    logic          sa;
    logic          sb;
    logic          dzi;
    logic [WL-1:0] eq;
    logic [WL-1:0] er;
    logic          eovf;
    logic          edz;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [WL-1:0] q_mag;
  logic [WL-1:0] r_mag;
  logic          sign_a;
  logic          sign_b;
  logic          div_zero;
  logic          out_valid;
  logic          out_ready;
  logic [WL-1:0] quot;
  logic [WL-1:0] rem;
  logic          ovf;
  logic          dz;
  logic [CW-1:0] ovf_cnt;

  div_sign_restore #(.WL(WL), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .q_mag(q_mag), .r_mag(r_mag), .sign_a(sign_a), .sign_b(sign_b),
    .div_zero(div_zero), .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .ovf(ovf), .dz(dz), .ovf_cnt(ovf_cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  logic [EW-1:0] exp_q[$];
  logic [CW-1:0] exp_cnt = '0;
  vec_t tab[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: checks the head beat every cycle it is presented
  always @(negedge clk) begin
    #3;
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(out_valid), 32'd0);
      end else begin
        check("out_beat", 32'({quot, rem, ovf, dz}), 32'(exp_q[0]));
        check("ovf_cnt_live", 32'(ovf_cnt), 32'(exp_cnt));
        if (out_ready === 1'b1) begin
          if (exp_q[0][1] && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic send(input vec_t v);
    int   guard;
    logic ok;
    logic done;
    guard = 0;
    done  = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    q_mag    = v.q;
    r_mag    = v.r;
    sign_a   = v.sa;
    sign_b   = v.sb;
    div_zero = v.dzi;
    while (!done) begin
      #2;
      ok = in_ready;
      @(posedge clk);
      if (ok) begin
        exp_q.push_back({v.eq, v.er, v.eovf, v.edz});
        n_acc++;
        done = 1'b1;
      end else if (guard > 50) begin
        check("send_timeout", 32'd1, 32'd0);
        done = 1'b1;
      end else begin
        guard++;
        @(negedge clk);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 60) begin
      @(negedge clk);
      g++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    //            q      r      sa    sb    dz    quot   rem    ovf   dz
    tab[0]  = '{8'h03, 8'h01, 1'b1, 1'b0, 1'b0, 8'hFD, 8'hFF, 1'b0, 1'b0};
    tab[1]  = '{8'h03, 8'h01, 1'b0, 1'b1, 1'b0, 8'hFD, 8'h01, 1'b0, 1'b0};
    tab[2]  = '{8'h03, 8'h01, 1'b1, 1'b1, 1'b0, 8'h03, 8'hFF, 1'b0, 1'b0};
    tab[3]  = '{8'h03, 8'h01, 1'b0, 1'b0, 1'b0, 8'h03, 8'h01, 1'b0, 1'b0};
    tab[4]  = '{8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 8'h7F, 8'h00, 1'b1, 1'b0};
    tab[5]  = '{8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0};
    tab[6]  = '{8'h00, 8'h05, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFB, 1'b0, 1'b1};
    tab[7]  = '{8'h00, 8'h09, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h09, 1'b0, 1'b1};
    tab[8]  = '{8'h81, 8'h02, 1'b0, 1'b1, 1'b0, 8'h80, 8'h02, 1'b1, 1'b0};
    tab[9]  = '{8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 8'h7F, 8'h00, 1'b0, 1'b0};
    tab[10] = '{8'h7F, 8'h03, 1'b1, 1'b0, 1'b0, 8'h81, 8'hFD, 1'b0, 1'b0};
    tab[11] = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h7F, 8'h00, 1'b1, 1'b0};
    tab[12] = '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    tab[13] = '{8'hFF, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    q_mag     = '0;
    r_mag     = '0;
    sign_a    = 1'b0;
    sign_b    = 1'b0;
    div_zero  = 1'b0;
    out_ready = 1'b1;

    // reset values, during and after reset
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", 32'({quot, rem, ovf, dz}), 32'd0);
    check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // latency: accepted at edge N, out_valid after edge N+1 (two edges after drive)
    send(tab[0]);
    idle();
    #1;
    check("lat_not_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    check("lat_valid", 32'(out_valid), 32'd1);
    drain();

    // table vectors, back to back
    for (int i = 0; i < 14; i++) send(tab[i]);
    idle();
    drain();
    // ovf beats in table: 4, 8, 11, 4 was also... count saturates at 3
    #1;
    check("table_ovf_cnt", 32'(ovf_cnt), 32'd3);

    // backpressure: 5 beats against a 4-cycle stall
    do_reset();
    @(negedge clk);
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(tab[i + 6]);
        idle();
      end
      begin
        repeat (4) @(negedge clk);
        #1;
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_accepted", 32'(n_acc), 32'd2);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_total", 32'(n_acc), 32'd5);

    // counter saturation with CW=2
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send(tab[4]);
      idle();
      drain();
      #1;
      check("sat_cnt", 32'(ovf_cnt), 32'(sat_exp[k]));
    end

    // reset mid-stream with both stages full
    out_ready = 1'b0;
    send(tab[0]);
    send(tab[1]);
    idle();
    #1;
    check("mid_full", 32'({out_valid, in_ready}), 32'b10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_cnt", 32'(ovf_cnt), 32'd0);
    check("mid_rst_outputs", 32'({quot, rem, ovf, dz}), 32'd0);
    exp_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("mid_in_ready", 32'(in_ready), 32'd1);
    repeat (5) begin
      @(negedge clk);
      #1;
      check("no_stale_beat", 32'(out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
